// File: rtl/mips_cpu_writeback_arbiter.sv
// Register-file writeback arbiter: ALU > {load, mul/div round-robin}, with a
// pending-write scoreboard. Define MIPS_CPU_WB_FORWARD_EN to add forwarding outputs.
module mips_cpu_writeback_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    input  logic [4:0]  ld_reg,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        md_valid,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    input  logic [4:0]  query_reg_1,
    input  logic [4:0]  query_reg_2,
    output logic        pending_1,
    output logic        pending_2,
`ifdef MIPS_CPU_WB_FORWARD_EN
    output logic        fwd_hit_1,
    output logic        fwd_hit_2,
    output logic [31:0] fwd_data_1,
    output logic [31:0] fwd_data_2,
`endif
    output logic        write_enable,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data
);

    typedef enum logic {RR_LD = 1'b0, RR_MD = 1'b1} rr_t;

    rr_t         rr;
    logic [31:0] pend, pend_nxt, clr_mask, set_mask;
    logic        ld_win, md_win;
    logic        g_valid;
    logic [4:0]  g_reg;
    logic [31:0] g_data;

    // Round-robin only matters when both long-latency sources contend.
    assign ld_win   = ld_valid & (~md_valid | (rr == RR_LD));
    assign md_win   = md_valid & (~ld_valid | (rr == RR_MD));
    assign ld_ready = reset_n & ~alu_valid & ld_win;
    assign md_ready = reset_n & ~alu_valid & md_win;

    always_comb begin
        g_valid = 1'b0;
        g_reg   = 5'd0;
        g_data  = 32'd0;
        if (alu_valid) begin
            g_valid = 1'b1;
            g_reg   = alu_reg;
            g_data  = alu_data;
        end else if (ld_ready) begin
            g_valid = 1'b1;
            g_reg   = ld_reg;
            g_data  = ld_data;
        end else if (md_ready) begin
            g_valid = 1'b1;
            g_reg   = md_reg;
            g_data  = md_data;
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the bit pending.
    always_comb begin
        clr_mask = 32'd0;
        set_mask = 32'd0;
        if (ld_ready)    clr_mask = clr_mask | (32'd1 << ld_reg);
        if (md_ready)    clr_mask = clr_mask | (32'd1 << md_reg);
        if (issue_valid) set_mask = 32'd1 << issue_reg;
        pend_nxt = ((pend & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_enable <= 1'b0;
            write_reg    <= 5'd0;
            write_data   <= 32'd0;
            pend         <= 32'd0;
            rr           <= RR_LD;
        end else begin
            write_enable <= g_valid & (g_reg != 5'd0);
            if (g_valid) begin
                write_reg  <= g_reg;
                write_data <= g_data;
            end
            pend <= pend_nxt;
            if (ld_ready | md_ready)
                rr <= (rr == RR_LD) ? RR_MD : RR_LD;
        end
    end

    assign pending_1 = pend[query_reg_1];
    assign pending_2 = pend[query_reg_2];

`ifdef MIPS_CPU_WB_FORWARD_EN
    assign fwd_hit_1  = write_enable & (write_reg == query_reg_1) & (query_reg_1 != 5'd0);
    assign fwd_hit_2  = write_enable & (write_reg == query_reg_2) & (query_reg_2 != 5'd0);
    assign fwd_data_1 = write_data;
    assign fwd_data_2 = write_data;
`endif

endmodule

// File: tb/tb_mips_cpu_writeback_arbiter.sv
// Randomized + directed bench for mips_cpu_writeback_arbiter against a
// cycle-level reference model of the arbitration and scoreboard rules.
module tb_mips_cpu_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        alu_valid = 0, ld_valid = 0, md_valid = 0, issue_valid = 0;
    logic [4:0]  alu_reg = 0, ld_reg = 0, md_reg = 0, issue_reg = 0;
    logic [31:0] alu_data = 0, ld_data = 0, md_data = 0;
    logic [4:0]  query_reg_1 = 0, query_reg_2 = 0;
    logic        ld_ready, md_ready, pending_1, pending_2, write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
`ifdef MIPS_CPU_WB_FORWARD_EN
    logic        fwd_hit_1, fwd_hit_2;
    logic [31:0] fwd_data_1, fwd_data_2;
`endif

    always #5 clk = ~clk;

    mips_cpu_writeback_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .query_reg_1(query_reg_1), .query_reg_2(query_reg_2),
        .pending_1(pending_1), .pending_2(pending_2),
`ifdef MIPS_CPU_WB_FORWARD_EN
        .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
`endif
        .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_pend [32];
    bit          m_rr_ld;
    bit          m_we;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    bit          last_gl, last_gm;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_query(input logic [4:0] q);
        return (q != 0) && m_pend[q];
    endfunction

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic step();
        bit          ga, gl, gm, ne;
        bit          np [32];
        logic [4:0]  nr;
        logic [31:0] nd;
        #1;
        ga = alu_valid; gl = 0; gm = 0;
        if (!alu_valid) begin
            if (ld_valid && md_valid) begin gl = m_rr_ld; gm = !m_rr_ld; end
            else begin gl = ld_valid; gm = md_valid; end
        end
        chk("ld_ready", ld_ready, gl);
        chk("md_ready", md_ready, gm);
        chk("pending_1", pending_1, m_query(query_reg_1));
        chk("pending_2", pending_2, m_query(query_reg_2));
        np = m_pend; ne = 0; nr = m_wreg; nd = m_wdata;
        if (ga)      begin ne = (alu_reg != 0); nr = alu_reg; nd = alu_data; end
        else if (gl) begin ne = (ld_reg != 0);  nr = ld_reg;  nd = ld_data;  np[ld_reg] = 0; end
        else if (gm) begin ne = (md_reg != 0);  nr = md_reg;  nd = md_data;  np[md_reg] = 0; end
        if (issue_valid && issue_reg != 0) np[issue_reg] = 1;
        last_gl = gl; last_gm = gm;
        @(posedge clk);
        m_pend = np; m_we = ne; m_wreg = nr; m_wdata = nd;
        if (gl || gm) m_rr_ld = !m_rr_ld;
        @(negedge clk);
        chk("write_enable", write_enable, m_we);
        if (m_we) begin
            chk("write_reg", write_reg, m_wreg);
            chk("write_data", write_data, m_wdata);
        end
`ifdef MIPS_CPU_WB_FORWARD_EN
        chk("fwd_hit_1", fwd_hit_1, m_we && m_wreg == query_reg_1 && query_reg_1 != 0);
        chk("fwd_hit_2", fwd_hit_2, m_we && m_wreg == query_reg_2 && query_reg_2 != 0);
        if (m_we) chk("fwd_data_1", fwd_data_1, m_wdata);
`endif
    endtask

    // Asserts reset at a negedge with sources still presenting; releases one cycle later.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_we", write_enable, 0);
        chk("rst_wreg", write_reg, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_md_ready", md_ready, 0);
        chk("rst_pending_1", pending_1, 0);
        chk("rst_pending_2", pending_2, 0);
        foreach (m_pend[i]) m_pend[i] = 0;
        m_rr_ld = 1; m_we = 0; m_wreg = 0; m_wdata = 0;
        last_gl = 0; last_gm = 0;
        @(negedge clk);
        reset_n = 1'b1;
        alu_valid = 0; ld_valid = 0; md_valid = 0; issue_valid = 0;
    endtask

    initial begin
        do_reset();

        // ALU result lands one cycle later
        alu_valid = 1; alu_reg = 5; alu_data = 32'h1234;
        step();
        chk("alu_we", write_enable, 1);
        chk("alu_reg", write_reg, 5);
        chk("alu_data", write_data, 32'h1234);
        alu_valid = 0;

        // ALU blocks load for two cycles
        alu_valid = 1; alu_reg = 3; alu_data = 32'h33;
        ld_valid = 1; ld_reg = 9; ld_data = 32'hAAAA;
        step(); step();
        alu_valid = 0;
        step();
        chk("ld_after_alu", write_reg, 9);
        ld_valid = 0;

        // Alternation from reset starts with load
        do_reset();
        ld_valid = 1; ld_reg = 10; ld_data = 32'h10;
        md_valid = 1; md_reg = 11; md_data = 32'h11;
        step(); chk("rr0", write_reg, 10);
        step(); chk("rr1", write_reg, 11);
        step(); chk("rr2", write_reg, 10);
        step(); chk("rr3", write_reg, 11);
        ld_valid = 0; md_valid = 0;

        // Scoreboard set, held, then cleared by mul/div grant
        issue_valid = 1; issue_reg = 8; query_reg_1 = 8; query_reg_2 = 0;
        step();
        issue_valid = 0;
        #1 chk("pend_set", pending_1, 1);
        step();
        md_valid = 1; md_reg = 8; md_data = 32'h88;
        step();
        md_valid = 0;
        #1 chk("pend_clr", pending_1, 0);

        // Issue wins over same-cycle load clear
        issue_valid = 1; issue_reg = 8;
        ld_valid = 1; ld_reg = 8; ld_data = 32'h8;
        step();
        issue_valid = 0; ld_valid = 0;
        #1 chk("pend_set_wins", pending_1, 1);

        // Load to r0 handshakes but does not write
        ld_valid = 1; ld_reg = 0; ld_data = 32'hDEAD;
        step();
        chk("r0_we", write_enable, 0);
        ld_valid = 0;

        // Random traffic with a reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            alu_valid = ($urandom_range(0, 3) == 0);
            alu_reg = 5'($urandom_range(0, 7)); alu_data = $urandom;
            if (!(ld_valid && !last_gl)) begin
                ld_valid = $urandom_range(0, 1) != 0;
                ld_reg = 5'($urandom_range(0, 7)); ld_data = $urandom;
            end
            if (!(md_valid && !last_gm)) begin
                md_valid = $urandom_range(0, 1) != 0;
                md_reg = 5'($urandom_range(0, 7)); md_data = $urandom;
            end
            issue_valid = $urandom_range(0, 1) != 0;
            issue_reg = 5'($urandom_range(0, 7));
            query_reg_1 = 5'($urandom_range(0, 7));
            query_reg_2 = 5'($urandom_range(0, 7));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
